// File: rtl/tx_symb_index_ctrl.sv
// rtl/tx_symb_index_ctrl.sv - Tx symbol index tracker across IFFT/CP latency.
// Optional macro TX_IDX_ERR_EN builds the sticky err_flags detection.
module tx_symb_index_ctrl #(
    parameter int SYMB_PER_FRAME = 100,
    parameter int IDX_W          = 7,
    parameter int DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       ifft_sop,
    input  logic                       cp_sop,
    output logic                       busy,
    output logic                       frame_done,
    output logic [IDX_W-1:0]           symb_idx_out,
    output logic                       last_symb_out,
    output logic                       idx_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [2:0]                 err_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  symb_cnt;
    logic [IDX_W-1:0]  cnt_nxt;
    logic              done_nxt;

    logic [IDX_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              is_last;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;

    assign is_last  = (symb_cnt == IDX_W'(SYMB_PER_FRAME - 1));
    assign push_req = (state == RUN) && ifft_sop;
    assign empty    = (fifo_level == '0);
    assign full     = (fifo_level == LW'(DEPTH));
    assign pop      = cp_sop && !empty;
    // A full FIFO still accepts the push when the same cycle frees a slot.
    assign push     = push_req && (!full || pop);
    assign busy     = (state == RUN);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = symb_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (ifft_sop) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = symb_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            symb_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            symb_cnt   <= cnt_nxt;
            frame_done <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= symb_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            symb_idx_out  <= '0;
            last_symb_out <= 1'b0;
            idx_valid     <= 1'b0;
        end else begin
            idx_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                symb_idx_out  <= mem[rd_ptr];
                last_symb_out <= (mem[rd_ptr] == IDX_W'(SYMB_PER_FRAME - 1));
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

`ifdef TX_IDX_ERR_EN
    logic restart_hit;
    logic overflow_hit;
    logic underflow_hit;

    assign restart_hit   = (state == RUN) && frame_start;
    assign overflow_hit  = push_req && full && !pop;
    assign underflow_hit = cp_sop && empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_flags <= 3'b000;
        end else begin
            err_flags <= err_flags | {restart_hit, overflow_hit, underflow_hit};
        end
    end
`else
    assign err_flags = 3'b000;
`endif

endmodule

// File: tb/tb_tx_symb_index_ctrl.sv
// tb/tb_tx_symb_index_ctrl.sv - Self-checking bench for tx_symb_index_ctrl.
module tb_tx_symb_index_ctrl;

    localparam int SPF   = 4;
    localparam int IDX_W = 7;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             frame_start = 1'b0;
    logic             ifft_sop = 1'b0;
    logic             cp_sop = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [IDX_W-1:0] symb_idx_out;
    logic             last_symb_out;
    logic             idx_valid;
    logic [2:0]       fifo_level;
    logic [2:0]       err_flags;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    tx_symb_index_ctrl #(
        .SYMB_PER_FRAME(SPF),
        .IDX_W(IDX_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .ifft_sop(ifft_sop),
        .cp_sop(cp_sop),
        .busy(busy),
        .frame_done(frame_done),
        .symb_idx_out(symb_idx_out),
        .last_symb_out(last_symb_out),
        .idx_valid(idx_valid),
        .fifo_level(fifo_level),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of in-flight indices plus a frame counter.
    int   m_q[$];
    bit   m_run = 0;
    int   m_cnt = 0;
    int   m_idx = 0;
    bit   m_last = 0;
    bit   m_valid = 0;
    bit   m_done = 0;
    bit [2:0] m_err = 3'b000;

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_run = 0; m_cnt = 0; m_idx = 0; m_last = 0;
            m_valid = 0; m_done = 0; m_err = 3'b000;
        end else begin
            bit pop_ok;
            pop_ok  = cp_sop && (m_q.size() > 0);
            m_valid = pop_ok;
            m_done  = 0;
            if (cp_sop && !pop_ok) m_err[0] = 1'b1;
            if (pop_ok) begin
                m_idx  = m_q.pop_front();
                m_last = (m_idx == SPF - 1);
            end
            if (m_run) begin
                if (frame_start) m_err[2] = 1'b1;
                if (ifft_sop) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_cnt);
                    else m_err[1] = 1'b1;
                    if (m_cnt == SPF - 1) begin
                        m_cnt = 0; m_run = 0; m_done = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (frame_start) begin
                m_run = 1; m_cnt = 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            bit [2:0] exp_err;
`ifdef TX_IDX_ERR_EN
            exp_err = m_err;
`else
            exp_err = 3'b000;
`endif
            cmp("busy", int'(busy), int'(m_run));
            cmp("frame_done", int'(frame_done), int'(m_done));
            cmp("idx_valid", int'(idx_valid), int'(m_valid));
            cmp("symb_idx_out", int'(symb_idx_out), m_idx);
            cmp("last_symb_out", int'(last_symb_out), int'(m_last));
            cmp("fifo_level", int'(fifo_level), m_q.size());
            cmp("err_flags", int'(err_flags), int'(exp_err));
        end
    end

    task automatic step(input logic fs, input logic is, input logic cs);
        frame_start = fs;
        ifft_sop    = is;
        cp_sop      = cs;
        @(negedge clk);
        frame_start = 1'b0;
        ifft_sop    = 1'b0;
        cp_sop      = 1'b0;
    endtask

    function automatic int err_exp(input int v);
`ifdef TX_IDX_ERR_EN
        return v;
`else
        return (v & 0);
`endif
    endfunction

    initial begin
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b1;
        checking = 1'b1;
        cmp("lit_reset_level", int'(fifo_level), 0);
        cmp("lit_reset_busy", int'(busy), 0);
        cmp("lit_reset_err", int'(err_flags), 0);

        step(1, 0, 0);
        cmp("lit_busy_after_start", int'(busy), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        cmp("lit_level_peak", int'(fifo_level), 3);
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 4; w++) step(0, 0, 0);
            step(0, 0, 1);
            cmp("lit_pop_valid", int'(idx_valid), 1);
            cmp("lit_pop_idx", int'(symb_idx_out), k);
        end
        cmp("lit_level_drained", int'(fifo_level), 0);

        step(0, 1, 0);
        cmp("lit_frame_done", int'(frame_done), 1);
        cmp("lit_busy_end", int'(busy), 0);
        step(0, 0, 1);
        cmp("lit_last_idx", int'(symb_idx_out), 3);
        cmp("lit_last_flag", int'(last_symb_out), 1);
        step(0, 1, 0);
        cmp("lit_idle_sop_no_push", int'(fifo_level), 0);

        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        cmp("lit_full_level", int'(fifo_level), 4);
        step(1, 0, 0);
        step(0, 1, 0);
        cmp("lit_overflow_level", int'(fifo_level), 4);
        cmp("lit_overflow_flag", int'(err_flags), err_exp(3'b010));
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1);
            cmp("lit_drain_idx", int'(symb_idx_out), k);
            cmp("lit_drain_last", int'(last_symb_out), (k == 3) ? 1 : 0);
        end
        step(0, 0, 1);
        cmp("lit_underflow_valid", int'(idx_valid), 0);
        cmp("lit_underflow_hold", int'(symb_idx_out), 3);
        cmp("lit_underflow_flag", int'(err_flags), err_exp(3'b011));

        step(0, 1, 0);
        step(0, 1, 0);
        cmp("lit_level_two", int'(fifo_level), 2);
        step(0, 1, 1);
        cmp("lit_pushpop_level", int'(fifo_level), 2);
        cmp("lit_pushpop_idx", int'(symb_idx_out), 1);

        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        cmp("lit_restart_busy", int'(busy), 1);
        cmp("lit_restart_flag", int'(err_flags), err_exp(3'b111));
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        cmp("lit_final_with_start", int'(busy), 0);

        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        rst = 1'b0;
        step(0, 0, 0);
        rst = 1'b1;
        cmp("lit_midreset_level", int'(fifo_level), 0);
        cmp("lit_midreset_busy", int'(busy), 0);
        cmp("lit_midreset_err", int'(err_flags), 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_symb_index_ctrl.md
Name: tx_symb_index_ctrl

Overview:
Tx-side symbol index tracker for the OFDM modulator. Numbers each symbol of a frame as it enters the IFFT and carries that index across the IFFT/cyclic-prefix latency in a small FIFO. Re-emits the index aligned with the symbol's SOP at the CP-inserter output, so framing and pilot logic downstream see the correct symbol number.

Parameters:
SYMB_PER_FRAME, 100, symbols per frame; range 1..127.
IDX_W, 7, symbol index width.
DEPTH, 4, index FIFO depth; power of two, minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
frame_start  input  1  single-cycle pulse; arms a new frame
ifft_sop  input  1  SOP of a symbol entering the IFFT
cp_sop  input  1  SOP of a symbol leaving the CP inserter
busy  output  1  high while the frame is in RUN state
frame_done  output  1  single-cycle pulse after the last symbol is pushed
symb_idx_out  output  IDX_W  index of the current output symbol
last_symb_out  output  1  high when symb_idx_out = SYMB_PER_FRAME-1
idx_valid  output  1  single-cycle pulse, one cycle after an accepted cp_sop
fifo_level  output  $clog2(DEPTH)+1  number of indices in flight
err_flags  output  3  {restart_err, overflow, underflow}

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, symb_cnt=0, FIFO empty, all outputs 0. Reset applied mid-frame discards all in-flight indices.
- FSM IDLE -> RUN: on frame_start. symb_cnt is set to 0 and busy goes to 1 on the next cycle.
- FSM in RUN, on ifft_sop:
  - push symb_cnt into the FIFO;
  - if symb_cnt = SYMB_PER_FRAME-1: symb_cnt returns to 0, state goes to IDLE, and frame_done pulses on the following cycle;
  - otherwise symb_cnt increments by 1.
- FSM in RUN, on frame_start: the pulse is ignored, the frame continues, and restart_err is set.
- frame_start and the final ifft_sop in the same cycle: the push completes, the FSM goes to IDLE, and the frame_start is ignored with restart_err set.
- ifft_sop in IDLE: ignored, no push, no flag.
- Pop on cp_sop when the FIFO is non-empty, with the result registered one cycle later:
  - symb_idx_out <= head;
  - last_symb_out <= (head == SYMB_PER_FRAME-1);
  - idx_valid pulses for one cycle.
- symb_idx_out and last_symb_out hold their values until the next pop.
- cp_sop with the FIFO empty: underflow is set and the outputs keep their values. There is no bypass, so a same-cycle push does not satisfy the pop.
- Push with the FIFO full:
  - with a simultaneous pop: both operations proceed and the level is unchanged;
  - otherwise: the index is dropped, overflow is set, and symb_cnt still advances.
- Simultaneous push and pop with the FIFO non-empty: fifo_level is unchanged.
- Read and write pointers wrap modulo DEPTH; fifo_level is registered.
- err_flags bits are sticky and are cleared only by reset.

Optional Feature:
Macro TX_IDX_ERR_EN.
- Defined: err_flags behave as specified above.
- Not defined: err_flags is tied to 3'b000 and the detection logic is not built. Overflow and underflow handling (drop on full, hold outputs on empty) is unchanged.

Test Plan:
- Reset, then frame_start, then 3 ifft_sop, then 3 cp_sop each 5 cycles later -> idx_valid x3 with symb_idx_out 0,1,2; fifo_level peaks at 3 and returns to 0.
- SYMB_PER_FRAME=4: frame_start, then 4 ifft_sop each followed by a cp_sop -> frame_done one cycle after the 4th push; busy=0 afterwards; last_symb_out=1 only for index 3.
- Full frame of 4 symbols followed by a 5th ifft_sop -> no push, level unchanged; second frame_start then ifft_sop -> index 0 pushed.
- DEPTH=4: 5 ifft_sop with no cp_sop -> overflow=1, fifo_level=4; then 4 cp_sop -> indices 0,1,2,3.
- cp_sop with the FIFO empty -> underflow=1, idx_valid stays 0. ifft_sop and cp_sop in the same cycle at level 2 -> level stays 2 and the head index is output.
- frame_start mid-frame -> restart_err=1 and the count continues. rst=0 mid-frame -> level=0, busy=0, err_flags=0. Build without TX_IDX_ERR_EN -> err_flags stays 0 under overflow and underflow stimulus.
